// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Emits a registered one-cycle terminal-count pulse on expiry.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count      <= load_val;
                reload_reg <= load_val;
                state      <= (load_val != '0) ? RUN : IDLE;
            end else if (state == RUN && en) begin
                // RUN never holds a zero count, so expiry is always seen at 1.
                if (count == WIDTH'(1)) begin
                    tc <= 1'b1;
                    if (auto_reload) begin
                        count <= reload_reg;
                    end else begin
                        count <= '0;
                        state <= DONE;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Randomised and directed bench for down_counter against an arithmetic
// reference model of the timer behaviour.
module tb_down_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    int n_cmp;
    int n_err;

    // reference model: remaining count, reload value, running/expired flags
    int m_cnt;
    int m_rel;
    bit m_running;
    bit m_tc;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_rel     = 0;
        m_running = 0;
        m_tc      = 0;
    endtask

    task automatic model_clock(input bit ld, input int val, input bit e, input bit ar);
        m_tc = 0;
        if (ld) begin
            m_cnt     = val;
            m_rel     = val;
            m_running = (val != 0);
        end else if (m_running && e) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_tc = 1;
                if (ar) m_cnt = m_rel;
                else    m_running = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), m_cnt);
        check({tag, ".busy"},  int'(busy),  int'(m_running));
        check({tag, ".tc"},    int'(tc),    int'(m_tc));
    endtask

    // drive inputs, clock once, then compare 1 time unit after the edge
    task automatic step(input bit ld, input int val, input bit e, input bit ar, input string tag);
        load        = ld;
        load_val    = WIDTH'(val);
        en          = e;
        auto_reload = ar;
        @(posedge clk);
        model_clock(ld, val, e, ar);
        #1;
        check_all(tag);
    endtask

    initial begin
        int tc_seen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "idle_noload");

        // one-shot from 3
        step(1, 3, 1, 0, "os_load");
        check("os_load_cnt", int'(count), 3);
        step(0, 0, 1, 0, "os_2");
        step(0, 0, 1, 0, "os_1");
        step(0, 0, 1, 0, "os_0");
        check("os_tc_at_0", int'(tc), 1);
        check("os_busy_drop", int'(busy), 0);
        step(0, 0, 1, 0, "os_done");
        check("os_tc_once", int'(tc), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "done_hold");

        // auto-reload period 4
        step(1, 4, 1, 1, "ar_load");
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, "ar_run");
            if (tc) tc_seen++;
        end
        check("ar_tc_count", tc_seen, 3);
        check("ar_cnt_reload", int'(count), 4);

        // enable toggled
        step(1, 5, 0, 0, "en_load");
        tc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, (i % 2) == 0, 0, "en_toggle");
            if (tc) tc_seen++;
        end
        check("en_tc_count", tc_seen, 1);

        // load coincident with expiry
        step(1, 2, 1, 0, "lx_load");
        step(0, 0, 1, 0, "lx_1");
        step(1, 7, 1, 0, "lx_collide");
        check("lx_cnt", int'(count), 7);
        check("lx_tc", int'(tc), 0);

        // load of zero stays idle
        step(1, 0, 1, 1, "zero_load");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, "zero_idle");

        // asynchronous reset mid-count
        step(1, 3, 1, 0, "ar_mid_load");
        step(0, 0, 1, 0, "ar_mid_2");
        check("ar_mid_cnt", int'(count), 2);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit ld;
            ld = ($urandom_range(0, 99) < 12);
            step(ld, $urandom_range(0, (1 << WIDTH) - 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
